// File: rtl/pid_pkg.sv
// pid_pkg: shared types and constants for the PID MAC sequencer.
//   state_t  - sequencer FSM encoding
//   *_W      - datapath widths (error, derivative, multiplier operands, accumulator)
//   sat_out  - clip an accumulator-scale value to the signed 16-bit output range
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_ISSUE_P,
    S_ISSUE_I,
    S_ISSUE_D,
    S_DRAIN,
    S_OUT
  } state_t;

  localparam int ACC_W = 48;
  localparam int E_W   = 17;
  localparam int D_W   = 18;
  localparam int A_W   = 25;
  localparam int B_W   = 18;
  localparam int G_W   = 16;
  localparam int OUT_W = 16;
  localparam int P_W   = A_W + B_W;

  localparam logic signed [ACC_W-1:0] OUT_MAX = 32767;
  localparam logic signed [ACC_W-1:0] OUT_MIN = -32768;

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > OUT_MAX)
      return {1'b1, 16'h7fff};
    else if (v < OUT_MIN)
      return {1'b1, 16'h8000};
    else
      return {1'b0, v[OUT_W-1:0]};
  endfunction

endpackage

// File: rtl/pid_mult.sv
// pid_mult: signed 25x18 multiplier with LAT register stages and a matching
// valid pipe. Product appears LAT cycles after the operands are presented.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   in_valid, a, b operand pair (a 25b signed, b 18b signed)
//   out_valid      product valid
//   prod           43b signed product
module pid_mult
  import pid_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  output logic                  out_valid,
  output logic signed [P_W-1:0] prod
);

  logic signed [P_W-1:0] p_pipe [LAT];
  logic        [LAT-1:0] v_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      for (int k = 0; k < LAT; k++) p_pipe[k] <= '0;
    end else begin
      v_pipe[0] <= in_valid;
      p_pipe[0] <= a * b;
      for (int k = 1; k < LAT; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        p_pipe[k] <= p_pipe[k-1];
      end
    end
  end

  assign out_valid = v_pipe[LAT-1];
  assign prod      = p_pipe[LAT-1];

endmodule

// File: rtl/pid_mac_sequencer.sv
// pid_mac_sequencer: one PID loop evaluated on a single shared pipelined
// multiplier. Each accepted start computes e = command - sensor, updates the
// integrator and derivative, issues the P, I and D products back to back and
// emits a saturated 16-bit result (acc >>> SHIFT).
//
// Build option: define PID_INTEG_CLAMP_EN to clamp the integrator to
// +/-INTEG_LIM (anti-windup); otherwise it saturates at the INTEG_W range.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            compute request pulse (accepted only when busy=0)
//   command, sensor  signed 16b setpoint / measurement
//   p, i, d          unsigned Q4.12 gains
//   clear_integ      zero integrator and previous error
//   busy             computation in progress, through the done cycle
//   done             one-cycle pulse, result/sat updated
//   result, sat      signed 16b output and clip flag, held until next done
//   start_drop       one-cycle pulse, start discarded while busy
//
// state     | meaning
// S_IDLE    | waiting for start
// S_ERR     | compute e, d, integrator; latch gains; issue P pair
// S_ISSUE_P | P pair at multiplier; issue I pair
// S_ISSUE_I | I pair at multiplier; issue D pair
// S_ISSUE_D | D pair at multiplier; arm drain counter
// S_DRAIN   | wait until the D product has landed in acc
// S_OUT     | scale, saturate, register result, pulse done
module pid_mac_sequencer
  import pid_pkg::*;
#(
  parameter int MULT_LAT  = 2,
  parameter int INTEG_W   = 24,
  parameter int SHIFT     = 12,
  parameter int INTEG_LIM = 2**20 - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] command,
  input  logic [15:0] sensor,
  input  logic [15:0] p,
  input  logic [15:0] i,
  input  logic [15:0] d,
  input  logic        clear_integ,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        sat,
  output logic        start_drop
);

  if (MULT_LAT < 1 || INTEG_LIM < 1) begin : g_param_check
    $error("pid_mac_sequencer: MULT_LAT and INTEG_LIM must be >= 1");
  end

  localparam int CNT_W = $clog2(MULT_LAT) + 1;
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(MULT_LAT - 1);

`ifdef PID_INTEG_CLAMP_EN
  localparam logic signed [INTEG_W:0] INT_HI = (INTEG_W+1)'(INTEG_LIM);
  localparam logic signed [INTEG_W:0] INT_LO = -INT_HI;
`else
  localparam logic signed [INTEG_W:0] INT_HI = (INTEG_W+1)'((longint'(1) <<< (INTEG_W-1)) - 1);
  localparam logic signed [INTEG_W:0] INT_LO = -INT_HI - 1;
`endif

  state_t                    state;
  logic signed [INTEG_W-1:0] integ;
  logic signed [E_W-1:0]     e_prev;
  logic signed [D_W-1:0]     d_q;
  logic        [G_W-1:0]     gain_i;
  logic        [G_W-1:0]     gain_d;
  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   drain_cnt;

  logic                      mult_v;
  logic signed [A_W-1:0]     mult_a;
  logic signed [B_W-1:0]     mult_b;
  logic                      mult_pv;
  logic signed [P_W-1:0]     mult_p;

  logic signed [15:0]        cmd_s;
  logic signed [15:0]        sen_s;
  logic signed [E_W-1:0]     e_now;
  logic signed [D_W-1:0]     d_now;
  logic signed [INTEG_W:0]   integ_sum;
  logic signed [INTEG_W-1:0] integ_next;

  always_comb begin
    cmd_s     = command;
    sen_s     = sensor;
    e_now     = E_W'(cmd_s) - E_W'(sen_s);
    d_now     = D_W'(e_now) - D_W'(e_prev);
    integ_sum = (INTEG_W+1)'(integ) + (INTEG_W+1)'(e_now);
    if (integ_sum > INT_HI)
      integ_next = INT_HI[INTEG_W-1:0];
    else if (integ_sum < INT_LO)
      integ_next = INT_LO[INTEG_W-1:0];
    else
      integ_next = integ_sum[INTEG_W-1:0];
  end

  pid_mult #(.LAT(MULT_LAT)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mult_v),
    .a         (mult_a),
    .b         (mult_b),
    .out_valid (mult_pv),
    .prod      (mult_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      sat        <= 1'b0;
      start_drop <= 1'b0;
      integ      <= '0;
      e_prev     <= '0;
      d_q        <= '0;
      gain_i     <= '0;
      gain_d     <= '0;
      acc        <= '0;
      drain_cnt  <= '0;
      mult_v     <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
    end else begin
      done       <= 1'b0;
      mult_v     <= 1'b0;
      // busy stays high through the done cycle, so a start there is dropped too
      start_drop <= start && busy;
      if (mult_pv) acc <= acc + ACC_W'(mult_p);

      case (state)
        S_IDLE: begin
          if (start && !busy) begin
            state <= S_ERR;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        S_ERR: begin
          acc    <= '0;
          e_prev <= e_now;
          integ  <= integ_next;
          d_q    <= clear_integ ? '0 : d_now;
          gain_i <= i;
          gain_d <= d;
          mult_a <= A_W'(e_now);
          mult_b <= {2'b00, p};
          mult_v <= 1'b1;
          state  <= S_ISSUE_P;
        end
        S_ISSUE_P: begin
          mult_a <= A_W'(integ);
          mult_b <= {2'b00, gain_i};
          mult_v <= 1'b1;
          state  <= S_ISSUE_I;
        end
        S_ISSUE_I: begin
          mult_a <= A_W'(d_q);
          mult_b <= {2'b00, gain_d};
          mult_v <= 1'b1;
          state  <= S_ISSUE_D;
        end
        S_ISSUE_D: begin
          drain_cnt <= DRAIN_INIT;
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          // MULT_LAT cycles: the D product is accumulated on the last one
          if (drain_cnt == '0)
            state <= S_OUT;
          else
            drain_cnt <= drain_cnt - 1'b1;
        end
        S_OUT: begin
          {sat, result} <= sat_out(acc >>> SHIFT);
          done          <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Clear has priority over the ERR update of the same cycle.
      if (clear_integ) begin
        integ  <= '0;
        e_prev <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pid_mac_sequencer.sv
module tb_pid_mac_sequencer;

  localparam int LAT = 2;
  localparam int EXP_LAT = 6 + LAT;
`ifdef PID_INTEG_CLAMP_EN
  localparam int TB_LIM = 150;
  localparam longint IHI = 150;
  localparam longint ILO = -150;
`else
  localparam int TB_LIM = 2**20 - 1;
  localparam longint IHI = 8388607;
  localparam longint ILO = -8388608;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] command, sensor, p_g, i_g, d_g;
  logic        clear_integ;
  logic        busy, done, sat, start_drop;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  longint m_integ = 0;
  longint m_eprev = 0;

  always #5 clk = ~clk;

  pid_mac_sequencer #(.MULT_LAT(LAT), .INTEG_LIM(TB_LIM)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .command     (command),
    .sensor      (sensor),
    .p           (p_g),
    .i           (i_g),
    .d           (d_g),
    .clear_integ (clear_integ),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .sat         (sat),
    .start_drop  (start_drop)
  );

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: PID law evaluated directly with wide integers.
  function automatic void model_run(input longint cmd, input longint sen, input longint pg,
                                    input longint ig, input longint dg, input bit clr_err,
                                    output longint res, output bit s);
    longint e, dv, acc, q;
    e = cmd - sen;
    if (clr_err) begin
      m_integ = 0;
      m_eprev = 0;
      dv = 0;
    end else begin
      m_integ = m_integ + e;
      if (m_integ > IHI) m_integ = IHI;
      if (m_integ < ILO) m_integ = ILO;
      dv = e - m_eprev;
      m_eprev = e;
    end
    acc = e * pg + m_integ * ig + dv * dg;
    q = acc >>> 12;
    s = 1'b0;
    res = q;
    if (q > 32767) begin res = 32767; s = 1'b1; end
    if (q < -32768) begin res = -32768; s = 1'b1; end
  endfunction

  task automatic clear_pulse();
    @(posedge clk); #1 clear_integ = 1'b1;
    @(posedge clk); #1 clear_integ = 1'b0;
    m_integ = 0;
    m_eprev = 0;
  endtask

  task automatic do_run(input int cmd, input int sen, input int pg, input int ig, input int dg,
                        input bit clr_err, output longint res, output bit s,
                        output int lat, output bit busy1);
    @(posedge clk); #1;
    command = 16'(cmd); sensor = 16'(sen);
    p_g = 16'(pg); i_g = 16'(ig); d_g = 16'(dg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    clear_integ = clr_err;
    lat = 1;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin
        clear_integ = 1'b0;
        command = 16'($urandom); sensor = 16'($urandom);
        p_g = 16'($urandom); i_g = 16'($urandom); d_g = 16'($urandom);
      end
    end while (!done && lat < 40);
    res = longint'($signed(result));
    s = sat;
  endtask

  typedef struct {
    int  cmd;
    int  sen;
    int  pg;
    int  ig;
    int  dg;
    bit  clr;
    int  exp_res;
    bit  exp_sat;
  } vec_t;

  vec_t vt[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint res, mres;
    bit     s, ms, b1;
    int     lat, n_done, n_drop;

    vt[0] = '{1000, 900, 4096, 0, 0, 1'b0, 100, 1'b0};
    vt[1] = '{100, 0, 0, 4096, 0, 1'b1, 100, 1'b0};
    vt[2] = '{100, 0, 0, 4096, 0, 1'b0, 200, 1'b0};
    vt[3] = '{100, 0, 0, 4096, 0, 1'b0, 300, 1'b0};
    vt[4] = '{100, 0, 0, 4096, 0, 1'b1, 100, 1'b0};
    vt[5] = '{100, 0, 0, 0, 4096, 1'b1, 100, 1'b0};
    vt[6] = '{40, 0, 0, 0, 4096, 1'b0, -60, 1'b0};
    vt[7] = '{32767, -32768, 65535, 0, 0, 1'b0, 32767, 1'b1};
    vt[8] = '{-32768, 32767, 65535, 0, 0, 1'b0, -32768, 1'b1};
    vt[9] = '{-1, 0, 1, 0, 0, 1'b0, -1, 1'b0};
`ifdef PID_INTEG_CLAMP_EN
    vt[2].exp_res = 150;
    vt[3].exp_res = 150;
`endif

    // Reset, with start asserted throughout
    rst = 1'b1; start = 1'b1; clear_integ = 1'b0;
    command = '0; sensor = '0; p_g = '0; i_g = '0; d_g = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_sat", sat, 0);
    check("reset_drop", start_drop, 0);
    rst = 1'b0; start = 1'b0;
    n_done = 0;
    repeat (12) begin @(posedge clk); #1; if (done) n_done++; end
    check("reset_no_done", n_done, 0);

    // Directed vector table
    for (int k = 0; k < 10; k++) begin
      if (vt[k].clr) clear_pulse();
      do_run(vt[k].cmd, vt[k].sen, vt[k].pg, vt[k].ig, vt[k].dg, 1'b0, res, s, lat, b1);
      model_run(vt[k].cmd, vt[k].sen, vt[k].pg, vt[k].ig, vt[k].dg, 1'b0, mres, ms);
      check($sformatf("vec%0d_result", k), res, vt[k].exp_res);
      check($sformatf("vec%0d_sat", k), s, vt[k].exp_sat);
      check($sformatf("vec%0d_latency", k), lat, EXP_LAT);
      check($sformatf("vec%0d_busy", k), b1, 1);
    end

    // Overlap: second start at cycle 3 is dropped
    @(posedge clk); #1;
    command = 16'(500); sensor = 16'(-200); p_g = 16'(8192); i_g = 16'(300); d_g = 16'(700);
    start = 1'b1;
    n_done = 0; n_drop = 0;
    for (int c = 1; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) begin n_done++; res = longint'($signed(result)); end
      if (start_drop) n_drop++;
      start = (c == 3);
    end
    model_run(500, -200, 8192, 300, 700, 1'b0, mres, ms);
    check("overlap_drops", n_drop, 1);
    check("overlap_dones", n_done, 1);
    check("overlap_result", res, mres);

    // Reset during a run: no done, integrator back to zero
    @(posedge clk); #1;
    command = 16'(100); sensor = '0; p_g = '0; i_g = 16'(4096); d_g = '0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_integ = 0; m_eprev = 0;
    n_done = 0;
    repeat (15) begin @(posedge clk); #1; if (done) n_done++; end
    check("abort_no_done", n_done, 0);
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    do_run(100, 0, 0, 4096, 0, 1'b0, res, s, lat, b1);
    model_run(100, 0, 0, 4096, 0, 1'b0, mres, ms);
    check("abort_integ_zero", res, 100);

    // Clear coincident with ERR: integ and d are zero for this run
    do_run(300, 0, 4096, 4096, 4096, 1'b1, res, s, lat, b1);
    model_run(300, 0, 4096, 4096, 4096, 1'b1, mres, ms);
    check("clr_err_result", res, 300);

    // Integrator pinned at its limit
    clear_pulse();
    for (int k = 0; k < 130; k++) begin
      do_run(32767, -32768, 0, 1, 0, 1'b0, res, s, lat, b1);
      model_run(32767, -32768, 0, 1, 0, 1'b0, mres, ms);
      check($sformatf("integ_sat%0d", k), res, mres);
    end

    // Randomized against the reference model
    for (int k = 0; k < 60; k++) begin
      int cmd, sen, pg, ig, dg;
      bit cb, ce;
      cmd = $signed(16'($urandom));
      sen = $signed(16'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        cmd = cmd / 64;
        sen = sen / 64;
      end
      pg = $urandom_range(0, 65535);
      ig = $urandom_range(0, 1) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 65535);
      dg = $urandom_range(0, 8191);
      cb = ($urandom_range(0, 7) == 0);
      ce = ($urandom_range(0, 7) == 0);
      if (cb) clear_pulse();
      do_run(cmd, sen, pg, ig, dg, ce, res, s, lat, b1);
      model_run(cmd, sen, pg, ig, dg, ce, mres, ms);
      check($sformatf("rand%0d_result", k), res, mres);
      check($sformatf("rand%0d_sat", k), s, ms);
      check($sformatf("rand%0d_latency", k), lat, EXP_LAT);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
